fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the core's decoder; produces the instruction word plus its PC.
- Owns the fetch PC and issues word requests to instruction memory over a req/ready + rvalid handshake.
- Buffers returned words in a small in-order FIFO; consumer pulls with a valid/ready handshake.
- Accepts branch/jump redirects from the execute side; flushes and discards stale in-flight responses.

---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 31 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Core-wide definitions shared by the fetch stage: datapath width, reset
// vector, canonical NOP and the fetch FSM encoding.
package core_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: instruction-memory request/response channel plus the
// valid/ready instruction stream handed to the decoder.
interface fetch_unit_if #(
  parameter int XLEN = core_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst_out;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output inst_valid, inst_out, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  inst_valid, inst_out, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head entry is visible combinationally so a
// word written on one edge appears at the output in the following cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             popData,
  input  logic                         flush,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign doPop   = pop && !empty;
  // A full FIFO still accepts a push when the same cycle frees the head slot.
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (doPush && !flush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word
// requests, buffers returned words in order and squashes stale responses on redirect.
module fetch_unit #(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    bus
);

  import core_pkg::*;

  localparam int         CW      = $clog2(DEPTH+1);
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = FS_IDLE;
  localparam logic [1:0] RUN   = FS_RUN;
  localparam logic [1:0] FLUSH = FS_FLUSH;

  logic [1:0]        state;
  logic [XLEN-1:0]   fetchPc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstandingNext;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     fifoCount;
  logic [CW-1:0]     pcqCount;
  logic              accept;
  logic              rsp;
  logic              rspLive;
  logic              fifoEmpty;
  logic              fifoFull;
  logic              pcqEmpty;
  logic              pcqFull;
  logic [XLEN-1:0]   pcqHead;
  logic [2*XLEN-1:0] fifoHead;
  logic              unusedBits;

  // Outstanding requests include stale ones, so the FIFO can never overflow.
  assign bus.imem_req  = (state != IDLE) && !redirect &&
                         (({1'b0, outstanding} + {1'b0, fifoCount}) < CREDITS);
  assign bus.imem_addr = fetchPc;

  assign accept          = bus.imem_req && bus.imem_ready;
  assign rsp             = bus.imem_rvalid && (outstanding != '0);
  assign rspLive         = rsp && (discard == '0) && !redirect;
  assign outstandingNext = outstanding + CW'(accept) - CW'(rsp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetchPc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstandingNext;
      if (redirect) begin
        fetchPc <= {redirect_pc[XLEN-1:2], 2'b00};
        discard <= outstandingNext;
        state   <= (outstandingNext != '0) ? FLUSH : RUN;
      end else begin
        if (accept) fetchPc <= fetchPc + XLEN'(4);
        if (rsp && (discard != '0)) discard <= discard - 1'b1;
        case (state)
          IDLE:    state <= RUN;
          FLUSH:   if (rsp && (discard == CW'(1))) state <= RUN;
          default: ;
        endcase
      end
    end
  end

  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) instFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rspLive),
    .pushData ({bus.imem_rdata, pcqHead}),
    .pop      (bus.inst_ready && !redirect),
    .popData  (fifoHead),
    .flush    (redirect),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Only live requests are queued here; stale ones left with the flush.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) pcQueue (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .pushData (fetchPc),
    .pop      (rspLive),
    .popData  (pcqHead),
    .flush    (redirect),
    .full     (pcqFull),
    .empty    (pcqEmpty),
    .count    (pcqCount)
  );

  assign bus.inst_valid = !fifoEmpty;
  assign bus.inst_out   = fifoHead[2*XLEN-1:XLEN];
  assign bus.inst_pc    = fifoHead[XLEN-1:0];

  assign unusedBits = &{1'b0, redirect_pc[1:0], fifoFull, pcqFull, pcqEmpty, pcqCount};

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a transaction-level memory and an expected
// decoder stream (queue of PCs) predict every output cycle by cycle.
module tb_fetch_unit;

  import core_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    int          due;
    bit          stale;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  req_t        pend[$];   // requests accepted by memory, in order
  logic [31:0] expQ[$];   // PCs the decoder should see, head first
  logic [31:0] nextPc;
  bit          idle;
  int total, bad, cyc, sinceRst, firstValidStep;
  int lat, pReady, pInst, pRedir, pSpur;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit forceRedir, input logic [31:0] tgt);
    bit          rsp, live, expReq, acc, cons, doRedir;
    req_t        it, nw;
    logic [31:0] target;
    int          d;
    doRedir = forceRedir || ($urandom_range(99) < pRedir);
    target  = forceRedir ? tgt :
              ($urandom_range(1) == 1 ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(15)));
    redirect       = doRedir;
    redirect_pc    = target;
    bus.inst_ready = ($urandom_range(99) < pInst);
    bus.imem_ready = ($urandom_range(99) < pReady);
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    bus.imem_rvalid = rsp;
    bus.imem_rdata  = rsp ? memWord(pend[0].pc) : $urandom;
    // Spurious response with nothing outstanding must be ignored.
    if (!rsp && pend.size() == 0 && $urandom_range(99) < pSpur) bus.imem_rvalid = 1'b1;
    #1;
    expReq = !idle && !doRedir && ((pend.size() + expQ.size()) < DEPTH);
    if (firstValidStep < 0 && bus.inst_valid === 1'b1) firstValidStep = sinceRst;
    check("inst_valid", 32'(bus.inst_valid), 32'(expQ.size() > 0));
    if (expQ.size() > 0) begin
      check("inst_pc", bus.inst_pc, expQ[0]);
      check("inst_out", bus.inst_out, memWord(expQ[0]));
    end
    check("imem_req", 32'(bus.imem_req), 32'(expReq));
    if (expReq) check("imem_addr", bus.imem_addr, nextPc);

    acc  = expReq && bus.imem_ready;
    cons = (expQ.size() > 0) && bus.inst_ready && !doRedir;
    live = 1'b0;
    if (rsp) begin
      it   = pend.pop_front();
      live = !it.stale && !doRedir;
    end
    if (doRedir) begin
      for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
      expQ.delete();
      nextPc = {target[31:2], 2'b00};
    end else begin
      if (cons) void'(expQ.pop_front());
      if (live) expQ.push_back(it.pc);
      if (acc) begin
        d = cyc + lat;
        if (pend.size() > 0 && pend[pend.size()-1].due >= d) d = pend[pend.size()-1].due + 1;
        nw.pc = nextPc; nw.due = d; nw.stale = 1'b0;
        pend.push_back(nw);
        nextPc = nextPc + 32'd4;
      end
    end
    idle = 1'b0;
    @(posedge clk);
    cyc++;
    sinceRst++;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    redirect = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_ready  = 1'b0;
    bus.inst_ready  = 1'b0;
    #1;
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", bus.imem_addr, RST_PC);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst_out", bus.inst_out, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
    pend.delete();
    expQ.delete();
    nextPc = RST_PC;
    idle = 1'b1;
    firstValidStep = -1;
    sinceRst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    total = 0; bad = 0; cyc = 0; sinceRst = 0; firstValidStep = -1;
    lat = 1; pReady = 100; pInst = 100; pRedir = 0; pSpur = 0;
    @(negedge clk);
    doReset();

    // Streaming from reset with a one-cycle memory.
    for (int k = 0; k < 12; k++) step(1'b0, '0);
    check("first_valid_latency", 32'(firstValidStep), 32'd3);

    // Decoder stalls: FIFO fills and requests stop.
    pInst = 0;
    for (int k = 0; k < 10; k++) step(1'b0, '0);
    #1;
    check("stall_req_low", 32'(bus.imem_req), 32'd0);
    check("stall_fifo_valid", 32'(bus.inst_valid), 32'd1);
    pInst = 100;
    for (int k = 0; k < 6; k++) step(1'b0, '0);

    // Memory back-pressure: address must hold.
    pReady = 0;
    for (int k = 0; k < 4; k++) step(1'b0, '0);
    pReady = 100;
    for (int k = 0; k < 4; k++) step(1'b0, '0);

    // Redirect with two requests in flight, three-cycle memory.
    lat = 3;
    for (int k = 0; k < 20 && pend.size() != 2; k++) step(1'b0, '0);
    check("two_in_flight_reached", 32'(pend.size()), 32'd2);
    step(1'b1, 32'h0000_0100);
    for (int k = 0; k < 12; k++) step(1'b0, '0);

    // Redirect colliding with a live response and a consumer pop.
    lat = 1;
    for (int k = 0; k < 20 && !(pend.size() > 0 && pend[0].due <= cyc && expQ.size() > 0); k++)
      step(1'b0, '0);
    check("collision_setup", 32'(pend.size() > 0 && expQ.size() > 0), 32'd1);
    step(1'b1, 32'h0000_0203);
    #1;
    check("redirect_addr_aligned", bus.imem_addr, 32'h0000_0200);
    check("redirect_fifo_empty", 32'(bus.inst_valid), 32'd0);
    for (int k = 0; k < 6; k++) step(1'b0, '0);

    // Randomized traffic with redirects, back-pressure and spurious rvalid.
    pReady = 70; pInst = 60; pRedir = 5; pSpur = 5;
    for (int blk = 0; blk < 8; blk++) begin
      lat = $urandom_range(1, 4);
      for (int k = 0; k < 50; k++) step(1'b0, '0);
    end

    // Reset mid-stream with a full FIFO.
    pReady = 100; pInst = 0; pRedir = 0; pSpur = 0; lat = 1;
    for (int k = 0; k < 20 && expQ.size() != DEPTH; k++) step(1'b0, '0);
    check("full_before_reset", 32'(expQ.size()), 32'(DEPTH));
    doReset();
    pInst = 100;
    for (int k = 0; k < 10; k++) step(1'b0, '0);
    check("restart_first_valid", 32'(firstValidStep), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
